// File: rtl/compress_pkg.sv
// Shared types and helpers for the compress_packer lane re-packer.
package compress_pkg;

    typedef enum logic {RUN, FLUSH} pack_state_e;

    localparam int DEF_DW = 32;
    localparam int DEF_N  = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef logic [DEF_N-1:0][DEF_DW-1:0] lane_arr_t;

endpackage

// File: rtl/compress_lane_merge.sv
// Concatenates the first i_fill residue lanes with the first i_cnt input lanes.
// Every lane at or above fill+cnt is zero.
module compress_lane_merge
    import compress_pkg::*;
#(
    parameter int DW = 32,
    parameter int N  = 8,
    parameter int CW = cnt_w(N)
) (
    input  logic [(N-1)*DW-1:0]   i_res,
    input  logic [CW-1:0]         i_fill,
    input  logic [N-1:0][DW-1:0]  i_lanes,
    input  logic [CW-1:0]         i_cnt,
    output logic [(2*N-1)*DW-1:0] o_merged
);
    logic [N*DW-1:0]     w_in_m;
    logic [(N-1)*DW-1:0] w_res_m;

    always_comb begin
        w_in_m  = '0;
        w_res_m = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < i_cnt) w_in_m[i*DW +: DW] = i_lanes[i];
        end
        for (int i = 0; i < N-1; i++) begin
            if (CW'(i) < i_fill) w_res_m[i*DW +: DW] = i_res[i*DW +: DW];
        end
    end

    // The input lanes land directly behind the live residue lanes.
    assign o_merged = ({{((N-1)*DW){1'b0}}, w_in_m} << (i_fill * DW))
                    | {{(N*DW){1'b0}}, w_res_m};

endmodule

// File: rtl/compress_packer.sv
// Packs variable-length lane prefixes into dense N-lane beats, with valid/ready
// flow control and a flush of the partial remainder on last.
module compress_packer
    import compress_pkg::*;
#(
    parameter int DW = 32,
    parameter int N  = 8,
    parameter int CW = cnt_w(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [N-1:0][DW-1:0] i_in_data,
    input  logic [CW-1:0]        i_in_cnt,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [N-1:0][DW-1:0] o_out_data,
    output logic [CW-1:0]        o_out_cnt,
    output logic                 o_out_last
);
    localparam logic [CW-1:0] LANES = CW'(N);

    pack_state_e            r_state, w_state_nxt;
    logic [CW-1:0]          r_fill, w_fill_nxt, w_cnt, w_total;
    logic [(N-1)*DW-1:0]    r_res, w_res_nxt;
    logic [(2*N-1)*DW-1:0]  w_merged;
    logic                   r_out_valid, r_out_last;
    logic [N*DW-1:0]        r_out_data, w_ld_data;
    logic [CW-1:0]          r_out_cnt, w_ld_cnt;
    logic                   w_slot_free, w_in_ready, w_load, w_ld_last;

    assign w_cnt       = (i_in_cnt > LANES) ? LANES : i_in_cnt;
    assign w_total     = r_fill + w_cnt;
    assign w_slot_free = !r_out_valid || i_out_ready;

    compress_lane_merge #(.DW(DW), .N(N), .CW(CW)) u_merge (
        .i_res    (r_res),
        .i_fill   (r_fill),
        .i_lanes  (i_in_data),
        .i_cnt    (w_cnt),
        .o_merged (w_merged)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
            r_fill  <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_res   <= w_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_res_nxt   = r_res;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = '0;
        w_ld_cnt    = '0;
        w_ld_last   = 1'b0;
        case (r_state)
            RUN: begin
                w_in_ready = w_slot_free && !i_rst;
                if (i_in_valid && w_in_ready) begin
                    if (w_total < LANES) begin
                        if (i_in_last) begin
                            w_load     = 1'b1;
                            w_ld_data  = w_merged[N*DW-1:0];
                            w_ld_cnt   = w_total;
                            w_ld_last  = 1'b1;
                            w_fill_nxt = '0;
                            w_res_nxt  = '0;
                        end else begin
                            w_fill_nxt = w_total;
                            w_res_nxt  = w_merged[(N-1)*DW-1:0];
                        end
                    end else begin
                        w_load     = 1'b1;
                        w_ld_data  = w_merged[N*DW-1:0];
                        w_ld_cnt   = LANES;
                        w_fill_nxt = w_total - LANES;
                        w_res_nxt  = w_merged[(2*N-1)*DW-1:N*DW];
                        // A last beat that overflows the output needs one more beat for its tail.
                        if (i_in_last) begin
                            if (w_total == LANES) w_ld_last   = 1'b1;
                            else                  w_state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = {{DW{1'b0}}, r_res};
                    w_ld_cnt    = r_fill;
                    w_ld_last   = 1'b1;
                    w_fill_nxt  = '0;
                    w_res_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ld_data;
            r_out_cnt   <= w_ld_cnt;
            r_out_last  <= w_ld_last;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_cnt   = r_out_cnt;
    assign o_out_last  = r_out_last;

endmodule

// File: doc/compress_packer.md
# compress_packer

Re-packs the compacted output of the `data_compress` lane compactor into dense N-lane beats. Each input beat carries a prefix of 0..N valid lanes. The block concatenates successive prefixes across beats and emits full N-lane beats. On `in_last` it flushes the remainder as a final partial beat. It sits directly downstream of the compactor and adds valid/ready flow control, which the compactor lacks.

## Interface
- `DW`, default 32: lane data width.
- `N`, default 8: lanes per beat; power of two, ≥2.
- `CW`: derived as `$clog2(N)+1`; count width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid & in_ready`.
- `in_data` in `[DW-1:0] x [N]`: lanes; only lanes `0..in_cnt-1` are meaningful.
- `in_cnt` in CW: number of valid prefix lanes, 0..N; values >N are treated as N.
- `in_last` in 1: end of frame; forces a flush.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accept.
- `out_data` out `[DW-1:0] x [N]`: packed lanes; lanes ≥`out_cnt` are driven 0.
- `out_cnt` out CW: valid lanes in the output beat; equals N except on a `last` beat.
- `out_last` out 1: final beat of the frame.

## Operation
- State:
  - residue buffer R holding N-1 lanes;
  - fill f, range 0..N-1;
  - one output register stage;
  - FSM {RUN, FLUSH}.
- Output slot free: `!out_valid | out_ready`.
- `in_ready`:
  - `= (state==RUN) & slot free`;
  - forced 0 while `rst` is high.
- On accept in RUN, let c = clamped `in_cnt` and t = f+c:
  - t<N, !last: append input lanes to R; f←t; no output.
  - t<N, last: emit {R, in lanes}, `out_cnt`=t, `out_last`=1; f←0.
  - t≥N, !last: emit R[0..f-1] followed by in[0..N-f-1], `out_cnt`=N; R←in[N-f..c-1]; f←t-N.
  - t==N, last: emit the full beat with `out_last`=1; f←0.
  - t>N, last: emit the full beat with `out_last`=0; R←remainder; f←t-N; go to FLUSH.
- FLUSH:
  - `in_ready`=0.
  - When the slot is free: emit R, `out_cnt`=f, `out_last`=1; f←0; return to RUN.
- c=0 with last and f=0: emit an empty beat, `out_cnt`=0, `out_last`=1. Frame boundaries are always preserved.
- c=0 without last: the beat is accepted and nothing changes.
- Output register holds `out_data`, `out_cnt` and `out_last` stable while `out_valid & !out_ready`.

## Timing
- Latency: an accepted beat that produces output shows `out_valid` on the next cycle.
- Throughput: one input beat per cycle in RUN with `out_ready`=1. Each `t>N & last` event costs one extra cycle (FLUSH).
- `in_ready` is combinational from `out_ready` and state. There is no combinational path from `in_valid` to `out_*`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_cnt`=0, `out_last`=0;
  - f=0, R=0, state=RUN.
- Reset asserted mid-frame or in FLUSH discards the residue and any held output beat immediately (asynchronous).

## Structure
- Package `compress_pkg` holds:
  - `typedef enum logic {RUN, FLUSH} pack_state_e`;
  - a `cnt_w(N)` function;
  - a lane-array typedef parameterised by DW/N.
- One sub-module, `compress_lane_merge`, which is combinational:
  - inputs: R, f, input lanes, c;
  - outputs: the 2N-1 lane concatenated vector, from which the output beat and the new residue are sliced.
- Top level holds the FSM, fill counter and output register.

## Test plan
All scenarios use N=8, DW=32, `out_ready`=1 unless stated.
1. `in_cnt`=5 (A0..A4), then `in_cnt`=5 (B0..B4):
   - no output after the first beat;
   - then one beat {A0..A4,B0..B2}, `out_cnt`=8, `out_last`=0;
   - f=2.
2. f=0, `in_cnt`=3 with `in_last`:
   - next cycle `out_cnt`=3, `out_last`=1;
   - `out_data` lanes 3..7 = 0; f=0.
3. f=6, `in_cnt`=7 with `in_last`:
   - beat `out_cnt`=8, `out_last`=0;
   - `in_ready`=0 for one cycle;
   - then beat `out_cnt`=5, `out_last`=1; back to RUN.
4. Output beat pending with `out_ready`=0 for 4 cycles:
   - `out_*` stable;
   - `in_ready`=0;
   - no input lost after `out_ready` returns.
5. f=0, `in_cnt`=0 with `in_last`: single beat `out_cnt`=0, `out_last`=1. Also `in_cnt`=9: behaves as 8.
6. Assert `rst` during FLUSH:
   - all outputs 0 in the same cycle;
   - after release, `in_ready`=1, and a fresh `in_cnt`=8 beat emits unchanged.
